// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fetch : multi-cycle instruction fetch stage, one request in      |
// |             flight, redirect-cancellable, valid/ready to decode.     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        inst_fault,
  output logic [63:0] fetch_cnt
);

  localparam logic [1:0] c_BOOT = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;

  logic        w_pc_aligned;
  logic        w_req_fire;

  assign w_pc_aligned = (pc_q[1:0] == 2'b00);
  assign w_req_fire   = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 64'd0;
      drop_q  <= 1'b0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    data_d  = data_q;
    fault_d = fault_q;
    case (state_q)
      c_BOOT: begin
        state_d = c_REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end
      c_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // Request already accepted for the old PC: its response must be discarded.
          if (w_req_fire) begin
            state_d = c_WAIT;
            drop_d  = 1'b1;
          end
        end else if (!w_pc_aligned) begin
          state_d = c_HOLD;
          fault_d = 1'b1;
          data_d  = 32'd0;
        end else if (w_req_fire) begin
          state_d = c_WAIT;
        end
      end
      c_WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            state_d = c_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = c_HOLD;
            data_d  = imem_resp_data;
            fault_d = imem_resp_err;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      c_HOLD: begin
        if (inst_ready) cnt_d = cnt_q + 64'd1;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = c_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = c_REQ;
        end
      end
      default: state_d = c_BOOT;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (state_q)
      c_REQ:   imem_req_valid = w_pc_aligned;
      c_HOLD:  inst_valid     = 1'b1;
      default: ;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign inst_pc       = pc_q;
  assign inst_data     = data_q;
  assign inst_fault    = fault_q;
  assign fetch_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifu_fetch : directed and random checks of ifu_fetch against a     |
// |                PC-sequence model and a behavioural instruction memory|
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_fault;
  logic [63:0] fetch_cnt;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_fault     (inst_fault),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_fire = 0;

  // Model: next PC decode should see, and instructions consumed so far.
  logic [63:0] exp_pc  = RESET_PC;
  logic [63:0] exp_cnt = 64'd0;

  // Memory: one pending response, delivered mem_lat cycles after acceptance.
  logic        pend        = 1'b0;
  int          pend_lat    = 0;
  logic [63:0] pend_addr   = 64'd0;
  int          mem_lat     = 1;
  logic        force_stale = 1'b0;
  logic [63:0] fire_q[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h8000_0017;
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return a[7:2] == 6'h3F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    logic fire;
    logic hs;
    fire = imem_req_valid && imem_req_ready;
    hs   = inst_valid && inst_ready;
    if (fire && !reset) begin
      check("one_outstanding", 64'(pend), 64'd0);
      fire_q.push_back(imem_req_addr);
      n_fire++;
      pend      = 1'b1;
      pend_lat  = mem_lat;
      pend_addr = imem_req_addr;
    end
    if (reset) begin
      exp_pc  = RESET_PC;
      exp_cnt = 64'd0;
    end else begin
      if (hs) begin
        exp_cnt = exp_cnt + 64'd1;
        exp_pc  = exp_pc + 64'd4;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    imem_resp_err   = 1'b0;
    if (pend) begin
      if (pend_lat <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = force_stale ? 32'hDEAD_BEEF : mem_word(pend_addr);
        imem_resp_err   = force_stale ? 1'b0 : mem_err(pend_addr);
        force_stale     = 1'b0;
        pend            = 1'b0;
      end else begin
        pend_lat--;
      end
    end
    check("req_addr", imem_req_addr, exp_pc);
    check("inst_pc", inst_pc, exp_pc);
    check("fetch_cnt", fetch_cnt, exp_cnt);
    if (inst_valid) begin
      if (exp_pc[1:0] != 2'b00) begin
        check("inst_data_mis", 64'(inst_data), 64'd0);
        check("inst_fault_mis", 64'(inst_fault), 64'd1);
      end else begin
        check("inst_data", 64'(inst_data), 64'(mem_word(exp_pc)));
        check("inst_fault", 64'(inst_fault), 64'(mem_err(exp_pc)));
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n;
    n = 0;
    while (!inst_valid && n < bound) begin
      tick();
      n++;
    end
    check(tag, 64'(inst_valid), 64'd1);
  endtask

  task automatic reset_checks();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_pc", inst_pc, RESET_PC);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    check("rst_inst_fault", 64'(inst_fault), 64'd0);
    check("rst_fetch_cnt", fetch_cnt, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int nf;
    logic [63:0] cnt0;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
    tick();
    tick();
    reset_checks();

    // Zero-wait memory, decode always ready: 3 cycles per instruction.
    reset = 1'b0; mem_lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    fire_q.delete();
    c0 = cyc;
    while (fetch_cnt != 64'd3 && cyc - c0 < 40) tick();
    check("loop_cycles", 64'(cyc - c0), 64'd10);
    check("loop_cnt", fetch_cnt, 64'd3);
    check("loop_nfire", 64'(fire_q.size()), 64'd3);
    if (fire_q.size() >= 3) begin
      check("loop_addr0", fire_q[0], 64'h8000_0000);
      check("loop_addr1", fire_q[1], 64'h8000_0004);
      check("loop_addr2", fire_q[2], 64'h8000_0008);
    end

    // Request backpressure for 5 cycles after a fresh reset.
    imem_req_ready = 1'b0; inst_ready = 1'b0; reset = 1'b1;
    tick();
    reset_checks();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_req_valid", 64'(imem_req_valid), 64'd1);
      check("bp_req_addr", imem_req_addr, 64'h8000_0000);
      check("bp_no_inst", 64'(inst_valid), 64'd0);
      tick();
    end
    mem_lat = 3; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("bp_wait_no_inst", 64'(inst_valid), 64'd0);
    wait_valid("bp_valid", 10);
    check("bp_data", 64'(inst_data), 64'h0000_0017);

    // Decode stall in HOLD: instruction stable, no new request.
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; imem_req_ready = 1'b1; mem_lat = 1;
    wait_valid("stall_valid", 10);
    nf = n_fire;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid_hold", 64'(inst_valid), 64'd1);
      check("stall_pc", inst_pc, 64'h8000_0004);
      check("stall_data", 64'(inst_data), 64'h0000_0013);
      check("stall_no_req", 64'(imem_req_valid), 64'd0);
      tick();
    end
    check("stall_no_fire", 64'(n_fire), 64'(nf));

    // Redirect while waiting: stale response must be dropped.
    inst_ready = 1'b1; imem_req_ready = 1'b0;
    tick();
    inst_ready = 1'b0; mem_lat = 3; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; force_stale = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    check("wait_redir_addr", imem_req_addr, 64'h8000_0100);
    check("wait_redir_no_req", 64'(imem_req_valid), 64'd0);
    imem_req_ready = 1'b1; mem_lat = 1;
    wait_valid("wait_redir_valid", 20);
    check("wait_redir_pc", inst_pc, 64'h8000_0100);
    check("wait_redir_data", 64'(inst_data), 64'h0000_0117);
    check("wait_redir_fire", fire_q[$], 64'h8000_0100);

    // Handshake and redirect in the same HOLD cycle.
    cnt0 = exp_cnt;
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    check("hs_redir_cnt", fetch_cnt, cnt0 + 64'd1);
    check("hs_redir_addr", imem_req_addr, 64'h8000_0200);
    check("hs_redir_req", 64'(imem_req_valid), 64'd1);
    wait_valid("hs_redir_valid", 10);
    check("hs_redir_fire", fire_q[$], 64'h8000_0200);

    // Redirect in HOLD without a handshake discards the instruction.
    cnt0 = exp_cnt;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    check("hold_redir_drop", 64'(inst_valid), 64'd0);
    check("hold_redir_cnt", fetch_cnt, cnt0);

    // Redirect to a misaligned PC in the cycle a request is accepted.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    nf = n_fire;
    wait_valid("mis_valid", 20);
    check("mis_fault", 64'(inst_fault), 64'd1);
    check("mis_pc", inst_pc, 64'h8000_0102);
    check("mis_data", 64'(inst_data), 64'd0);
    check("mis_no_fire", 64'(n_fire), 64'(nf));

    // Access fault reported by memory.
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_04FC;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    wait_valid("err_valid", 20);
    check("err_fault", 64'(inst_fault), 64'd1);
    check("err_pc", inst_pc, 64'h8000_04FC);
    check("err_data", 64'(inst_data), 64'h0000_04EB);

    // Reset while waiting; the abandoned response arrives after reset.
    inst_ready = 1'b1; mem_lat = 3;
    tick();
    inst_ready = 1'b0;
    tick();
    imem_req_ready = 1'b0; force_stale = 1'b1; reset = 1'b1;
    tick();
    reset_checks();
    reset = 1'b0; imem_req_ready = 1'b1; mem_lat = 1;
    wait_valid("rst_wait_valid", 20);
    check("rst_wait_pc", inst_pc, RESET_PC);
    check("rst_wait_data", 64'(inst_data), 64'h0000_0017);

    // Random traffic against the model.
    cnt0 = exp_cnt;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = ($urandom_range(0, 9) < 6);
      mem_lat        = int'($urandom_range(1, 4));
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC)};
      if ($urandom_range(0, 7) == 0) redirect_pc[1] = 1'b1;
      tick();
    end
    redirect_valid = 1'b0;
    check("rand_progress", 64'(exp_cnt > cnt0 + 64'd20), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Multi-cycle instruction fetch stage that replaces the zero-latency fetch path ahead of the decoder. It owns the architectural PC and issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response. It presents each fetched instruction to the decode stage over a valid/ready handshake. Redirects from branches, jumps, traps and `mret` arrive as a single merged redirect and cancel any in-flight work.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC after reset.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `redirect_valid` input 1: load a new PC this cycle.
- `redirect_pc` input 64: target PC.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_req_addr` output 64: fetch address, always equal to the PC.
- `imem_resp_valid` input 1: response valid; pulse, no backpressure.
- `imem_resp_data` input 32: instruction word.
- `imem_resp_err` input 1: access fault for this response.
- `inst_valid` output 1: instruction valid to decode.
- `inst_ready` input 1: decode consumes the instruction.
- `inst_pc` output 64: PC of the presented instruction.
- `inst_data` output 32: instruction word.
- `inst_fault` output 1: presented instruction is a fetch fault (access or misaligned).
- `fetch_cnt` output 64: count of instructions consumed by decode.

## Operation
- States: BOOT, REQ, WAIT, HOLD.
- Reset: state=BOOT and pc=RESET_PC. All outputs are 0, except `inst_pc` and `imem_req_addr`, which are RESET_PC.
- BOOT goes to REQ unconditionally on the next cycle.
- REQ: if pc[1:0] != 0, go to HOLD with inst_fault=1, inst_data=0, and no memory request. Otherwise `imem_req_valid`=1. When `imem_req_ready`=1, go to WAIT.
- WAIT: when `imem_resp_valid`=1, latch data and err into the output registers and go to HOLD.
- HOLD: `inst_valid`=1, with outputs stable until consumed. When `inst_valid && inst_ready`: pc <= pc+4 (64-bit wrap), increment `fetch_cnt`, go to REQ.
- `imem_resp_valid` outside WAIT is ignored. At most one request is outstanding.
- Redirect has priority over all other transitions. pc <= redirect_pc, then by state:
  - REQ: `imem_req_valid` stays 1 and the address changes next cycle. If the request was accepted the same cycle, handle it as in WAIT.
  - WAIT: set a drop flag, go to DRAIN behaviour. Remain in WAIT until the response arrives, discard it, clear the flag, go to REQ.
  - HOLD: a handshake in the same cycle completes normally (fetch_cnt increments, pc takes redirect_pc, not pc+4). Without a handshake, the held instruction is discarded, inst_valid drops next cycle, and fetch_cnt does not increment. Go to REQ in both cases.
  - Redirect while the drop flag is already set: update pc only; exactly one response is still discarded.
- `fetch_cnt` wraps modulo 2^64.

## Timing
- `imem_req_valid`, `imem_req_addr` and `inst_*` are driven from registers or state only. There are no combinational paths from `inst_ready`, `imem_req_ready` or `redirect_valid` to any output.
- Best-case loop, with request accepted in cycle T and response in T+1:
  - T+2: HOLD, inst_valid=1.
  - T+2: handshake.
  - T+3: REQ.
  - Throughput is 1 instruction per 3 cycles plus memory latency.
- Redirect in cycle T: `imem_req_addr`=redirect_pc from T+1. In WAIT, add the time until the outstanding response returns.
- Reset asserted in any state, including WAIT, returns to BOOT. A response arriving afterwards is ignored (BOOT/REQ ignore responses). Memory must tolerate one abandoned request.

## Test plan
- Reset then a zero-wait memory: `imem_req_addr` sequence is 0x8000_0000, 0x8000_0004, 0x8000_0008 with inst_ready=1. fetch_cnt=3 after the third handshake.
- `imem_req_ready` low for 5 cycles: `imem_req_valid` held high and addr stable at 0x8000_0000. No inst_valid until the response.
- `inst_ready` low 4 cycles in HOLD: inst_valid, inst_pc=0x8000_0004 and inst_data=0x00000013 are stable, and no new request is issued.
- Redirect to 0x8000_0100 while in WAIT: the stale response (0xDEADBEEF) is never presented. The next request addr is 0x8000_0100, and the first inst_pc after it is 0x8000_0100.
- Handshake plus redirect to 0x8000_0200 in the same HOLD cycle: fetch_cnt increments by 1 and the next request addr is 0x8000_0200.
- Redirect to 0x8000_0102: no memory request, inst_valid with inst_fault=1, inst_pc=0x8000_0102. A response with imem_resp_err=1 yields inst_fault=1 with the matching pc.
